// File: rtl/text_line_controller.sv
// Single-line text buffer shared by two requesters. Edits go to a shadow
// line, which is copied to the displayed line on a vblank rising edge.
module text_line_controller #(
    parameter int         MAX_CHARACTER_LINE = 10,
    parameter logic [7:0] BLANK_CHAR         = 8'h20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vblank,
    input  logic                            a_valid,
    input  logic [1:0]                      a_op,
    input  logic [7:0]                      a_data,
    output logic                            a_ready,
    input  logic                            b_valid,
    input  logic [1:0]                      b_op,
    input  logic [7:0]                      b_data,
    output logic                            b_ready,
    output logic [8*MAX_CHARACTER_LINE-1:0] the_line,
    output logic [3:0]                      cursor_pos,
    output logic                            line_full,
    output logic                            pending,
    output logic                            overflow
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'b00,
        OP_BACKSPACE = 2'b01,
        OP_CLEAR     = 2'b10,
        OP_SETCUR    = 2'b11
    } op_t;

    localparam logic [3:0] MAX_POS = 4'(MAX_CHARACTER_LINE);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_last_b;      // 1: B was granted most recently
    op_t        r_op;
    logic [7:0] r_data;
    logic [7:0] r_shadow [MAX_CHARACTER_LINE];
    logic [7:0] r_line   [MAX_CHARACTER_LINE];
    logic [3:0] r_cursor;
    logic       r_dirty;
    logic       r_overflow;
    logic       r_vblank_d;

    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_commit;
    logic [3:0] w_cursor_dec;
    logic [3:0] w_setcur_target;

    // Round-robin: a lone requester wins; on a tie the one not granted last wins.
    assign w_grant_a = a_valid && (!b_valid ||  r_last_b);
    assign w_grant_b = b_valid && (!a_valid || !r_last_b);

    // Display reload happens only when vblank rises and there is something new.
    assign w_commit = vblank && !r_vblank_d && r_dirty;

    assign w_cursor_dec    = r_cursor - 4'd1;
    assign w_setcur_target = (r_data[3:0] > MAX_POS) ? MAX_POS : r_data[3:0];

    // State register for the IDLE/EXEC handshake FSM.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and ready decode; ready is only ever offered in IDLE.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        w_state_next = r_state;
        a_ready      = 1'b0;
        b_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                a_ready = w_grant_a;
                b_ready = w_grant_b;
                if (w_grant_a || w_grant_b) w_state_next = EXEC;
            end
            EXEC:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Capture the accepted operation and remember who won arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
            r_op     <= OP_WRITE;
            r_data   <= 8'h00;
        end else if (a_ready) begin
            r_last_b <= 1'b0;
            r_op     <= op_t'(a_op);
            r_data   <= a_data;
        end else if (b_ready) begin
            r_last_b <= 1'b1;
            r_op     <= op_t'(b_op);
            r_data   <= b_data;
        end
    end

    // Apply the latched edit in EXEC and commit shadow to display on vblank rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: both line buffers are small register arrays that must power
            // up blank, so they are reset explicitly rather than left as RAM.
            for (int i = 0; i < MAX_CHARACTER_LINE; i++) begin
                r_shadow[i] <= BLANK_CHAR;
                r_line[i]   <= BLANK_CHAR;
            end
            r_cursor   <= 4'd0;
            r_dirty    <= 1'b0;
            r_overflow <= 1'b0;
            r_vblank_d <= 1'b0;
        end else begin
            r_vblank_d <= vblank;
            r_overflow <= 1'b0;

            // Commit sees the pre-edit shadow; an edit on the same edge keeps dirty set.
            if (w_commit) begin
                r_line  <= r_shadow;
                r_dirty <= 1'b0;
            end

            if (r_state == EXEC) begin
                case (r_op)
                    OP_WRITE: begin
                        r_dirty <= 1'b1;
                        if (r_cursor < MAX_POS) begin
                            r_shadow[r_cursor] <= r_data;
                            r_cursor           <= r_cursor + 4'd1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    OP_BACKSPACE: begin
                        if (r_cursor != 4'd0) begin
                            r_shadow[w_cursor_dec] <= BLANK_CHAR;
                            r_cursor               <= w_cursor_dec;
                            r_dirty                <= 1'b1;
                        end
                    end
                    OP_CLEAR: begin
                        for (int i = 0; i < MAX_CHARACTER_LINE; i++) begin
                            r_shadow[i] <= BLANK_CHAR;
                        end
                        r_cursor <= 4'd0;
                        r_dirty  <= 1'b1;
                    end
                    OP_SETCUR: r_cursor <= w_setcur_target;
                    default:   r_cursor <= r_cursor;
                endcase
            end
        end
    end

    // Character 0 occupies the most significant byte of the_line.
    for (genvar g = 0; g < MAX_CHARACTER_LINE; g++) begin : g_line_out
        assign the_line[8*(MAX_CHARACTER_LINE-g)-1 -: 8] = r_line[g];
    end

    assign cursor_pos = r_cursor;
    assign line_full  = (r_cursor == MAX_POS);
    assign pending    = r_dirty;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_text_line_controller.sv
// Directed bench for text_line_controller: reset, write/commit, arbitration,
// overflow, backspace, cursor set, edit/commit collision, reset during EXEC.
module tb_text_line_controller;

    localparam int         MAX    = 10;
    localparam logic [79:0] BLANKS = {10{8'h20}};
    localparam logic [1:0] OP_WR = 2'b00, OP_BS = 2'b01, OP_CLR = 2'b10, OP_SC = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblank = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]  a_op = 2'b00, b_op = 2'b00;
    logic [7:0]  a_data = 8'h00, b_data = 8'h00;
    logic        a_ready, b_ready;
    logic [79:0] the_line;
    logic [3:0]  cursor_pos;
    logic        line_full, pending, overflow;

    int checks   = 0;
    int failures = 0;

    text_line_controller #(.MAX_CHARACTER_LINE(MAX), .BLANK_CHAR(8'h20)) dut (
        .clk(clk), .rst(rst), .vblank(vblank),
        .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready),
        .the_line(the_line), .cursor_pos(cursor_pos), .line_full(line_full),
        .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Stimulus driver: issues one op and returns 1ns after the EXEC edge.
    task automatic do_op(input logic sel_b, input logic [1:0] op, input logic [7:0] data);
        int n = 0;
        if (sel_b) begin b_valid = 1'b1; b_op = op; b_data = data; end
        else       begin a_valid = 1'b1; a_op = op; a_data = data; end
        #1;
        while (!(sel_b ? b_ready : a_ready) && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL handshake_timeout: ready never seen for op %0b", op);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_vblank();
        vblank = 1'b1;
        @(posedge clk); #1;
        vblank = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; vblank = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        apply_reset();
        checks++; if (the_line !== BLANKS) begin failures++; $display("FAIL reset_line got=%h exp=%h", the_line, BLANKS); end
        checks++; if (cursor_pos !== 4'd0) begin failures++; $display("FAIL reset_cursor got=%0d exp=0", cursor_pos); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (line_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", line_full); end
        checks++; if ({a_ready, b_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {a_ready, b_ready}); end
    endtask

    task automatic test_write_commit();
        apply_reset();
        do_op(1'b0, OP_WR, 8'h48);
        do_op(1'b0, OP_WR, 8'h49);
        checks++; if (the_line !== BLANKS) begin failures++; $display("FAIL wc_line_held got=%h exp=%h", the_line, BLANKS); end
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL wc_pending_set got=%b exp=1", pending); end
        checks++; if (cursor_pos !== 4'd2) begin failures++; $display("FAIL wc_cursor got=%0d exp=2", cursor_pos); end
        vblank = 1'b1;
        @(posedge clk); #1;
        checks++; if (the_line !== {8'h48, 8'h49, {8{8'h20}}}) begin failures++; $display("FAIL wc_commit got=%h exp=%h", the_line, {8'h48, 8'h49, {8{8'h20}}}); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL wc_pending_clear got=%b exp=0", pending); end
        vblank = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        exp_a = 8'b0001_0001;   // bit i = expected a_ready in cycle i
        exp_b = 8'b0100_0100;
        apply_reset();
        a_valid = 1'b1; a_op = OP_SC; a_data = 8'h00;
        b_valid = 1'b1; b_op = OP_SC; b_data = 8'h00;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (a_ready !== exp_a[i]) begin failures++; $display("FAIL rr_a_ready cycle=%0d got=%b exp=%b", i, a_ready, exp_a[i]); end
            checks++; if (b_ready !== exp_b[i]) begin failures++; $display("FAIL rr_b_ready cycle=%0d got=%b exp=%b", i, b_ready, exp_b[i]); end
            if (i < 7) begin @(posedge clk); #2; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rr_setcur_clean got=%b exp=0", pending); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < MAX; i++) do_op(1'b0, OP_WR, 8'h30 + 8'(i));
        checks++; if (cursor_pos !== 4'd10) begin failures++; $display("FAIL ovf_cursor got=%0d exp=10", cursor_pos); end
        checks++; if (line_full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", line_full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        do_op(1'b1, OP_WR, 8'h58);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        @(posedge clk); #1;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
        checks++; if (cursor_pos !== 4'd10) begin failures++; $display("FAIL ovf_cursor_hold got=%0d exp=10", cursor_pos); end
        pulse_vblank();
        checks++; if (the_line !== 80'h30313233343536373839) begin failures++; $display("FAIL ovf_shadow got=%h exp=30313233343536373839", the_line); end
    endtask

    task automatic test_backspace();
        apply_reset();
        do_op(1'b0, OP_BS, 8'h00);
        checks++; if (cursor_pos !== 4'd0) begin failures++; $display("FAIL bs0_cursor got=%0d exp=0", cursor_pos); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL bs0_pending got=%b exp=0", pending); end
        do_op(1'b0, OP_WR, 8'h41);
        do_op(1'b1, OP_WR, 8'h42);
        do_op(1'b0, OP_WR, 8'h43);
        pulse_vblank();
        do_op(1'b1, OP_BS, 8'h00);
        checks++; if (cursor_pos !== 4'd2) begin failures++; $display("FAIL bs3_cursor got=%0d exp=2", cursor_pos); end
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL bs3_pending got=%b exp=1", pending); end
        pulse_vblank();
        checks++; if (the_line !== {8'h41, 8'h42, {8{8'h20}}}) begin failures++; $display("FAIL bs3_line got=%h exp=%h", the_line, {8'h41, 8'h42, {8{8'h20}}}); end
    endtask

    task automatic test_setcur();
        apply_reset();
        do_op(1'b0, OP_SC, 8'h0F);
        checks++; if (cursor_pos !== 4'd10) begin failures++; $display("FAIL sc_clamp got=%0d exp=10", cursor_pos); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL sc_pending got=%b exp=0", pending); end
        do_op(1'b1, OP_SC, 8'hA4);
        checks++; if (cursor_pos !== 4'd4) begin failures++; $display("FAIL sc_set got=%0d exp=4", cursor_pos); end
        do_op(1'b0, OP_WR, 8'h5A);
        pulse_vblank();
        checks++; if (the_line !== {{4{8'h20}}, 8'h5A, {5{8'h20}}}) begin failures++; $display("FAIL sc_write got=%h exp=%h", the_line, {{4{8'h20}}, 8'h5A, {5{8'h20}}}); end
    endtask

    task automatic test_coincident();
        apply_reset();
        do_op(1'b0, OP_WR, 8'h48);
        b_valid = 1'b1; b_op = OP_WR; b_data = 8'h58;
        #1;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL co_ready got=%b exp=1", b_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        vblank  = 1'b1;
        @(posedge clk); #1;
        checks++; if (the_line !== {8'h48, {9{8'h20}}}) begin failures++; $display("FAIL co_old_content got=%h exp=%h", the_line, {8'h48, {9{8'h20}}}); end
        checks++; if (pending !== 1'b1) begin failures++; $display("FAIL co_pending got=%b exp=1", pending); end
        vblank = 1'b0;
        @(posedge clk); #1;
        pulse_vblank();
        checks++; if (the_line !== {8'h48, 8'h58, {8{8'h20}}}) begin failures++; $display("FAIL co_next_commit got=%h exp=%h", the_line, {8'h48, 8'h58, {8{8'h20}}}); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL co_pending_clear got=%b exp=0", pending); end
    endtask

    task automatic test_reset_in_exec();
        apply_reset();
        do_op(1'b0, OP_WR, 8'h41);
        do_op(1'b0, OP_WR, 8'h42);
        pulse_vblank();
        do_op(1'b0, OP_WR, 8'h43);
        a_valid = 1'b1; a_op = OP_CLR; a_data = 8'h00;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rx_ready got=%b exp=1", a_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (the_line !== BLANKS) begin failures++; $display("FAIL rx_line got=%h exp=%h", the_line, BLANKS); end
        checks++; if (cursor_pos !== 4'd0) begin failures++; $display("FAIL rx_cursor got=%0d exp=0", cursor_pos); end
        checks++; if (pending !== 1'b0) begin failures++; $display("FAIL rx_pending got=%b exp=0", pending); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rx_overflow got=%b exp=0", overflow); end
        checks++; if (line_full !== 1'b0) begin failures++; $display("FAIL rx_full got=%b exp=0", line_full); end
        a_valid = 1'b1; b_valid = 1'b1; a_op = OP_SC; b_op = OP_SC;
        #1;
        checks++; if ({a_ready, b_ready} !== 2'b10) begin failures++; $display("FAIL rx_idle_grant got=%b exp=10", {a_ready, b_ready}); end
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        pulse_vblank();
        checks++; if (the_line !== BLANKS) begin failures++; $display("FAIL rx_no_stale got=%h exp=%h", the_line, BLANKS); end
    endtask

    initial begin
        test_reset();
        test_write_commit();
        test_round_robin();
        test_overflow();
        test_backspace();
        test_setcur();
        test_coincident();
        test_reset_in_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_line_controller.md
TEXT_LINE_CONTROLLER -- requirements
Module: text_line_controller

Interface
REQ-001 Parameter MAX_CHARACTER_LINE, default 10: number of characters in the line.
REQ-002 Parameter BLANK_CHAR, default 8'h20: fill code for empty positions.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port vblank  input  1  high outside the visible frame; level signal.
REQ-006 Port a_valid  input  1  requester A has an operation pending.
REQ-007 Port a_op  input  2  A operation: 00 WRITE, 01 BACKSPACE, 10 CLEAR, 11 SETCUR.
REQ-008 Port a_data  input  8  A character code, or cursor target in a_data[3:0] for SETCUR.
REQ-009 Port a_ready  output  1  A operation accepted this cycle.
REQ-010 Ports b_valid, b_op, b_data, b_ready  same widths and meanings as A, for requester B.
REQ-011 Port the_line  output  8*MAX_CHARACTER_LINE  displayed line; char 0 in bits [8*MAX-1 -: 8] (leftmost).
REQ-012 Port cursor_pos  output  4  next write index, 0..MAX_CHARACTER_LINE.
REQ-013 Port line_full  output  1  cursor_pos == MAX_CHARACTER_LINE.
REQ-014 Port pending  output  1  shadow differs from the_line (dirty flag).
REQ-015 Port overflow  output  1  one-cycle pulse when a WRITE is dropped because the line is full.

Function
REQ-016 The block SHALL keep a shadow line buffer edited by operations, and a display register driving the_line.
REQ-017 The FSM SHALL have two states, IDLE and EXEC; IDLE->EXEC on a handshake, EXEC->IDLE unconditionally.
REQ-018 In IDLE, a_ready/b_ready SHALL be combinational: only the granted requester's ready is high, and only if its valid is high; both are low in EXEC.
REQ-019 A transfer SHALL occur when valid && ready; op and data are latched on that edge; requesters hold valid/op/data until ready.
REQ-020 Arbitration SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not granted last.
REQ-021 The latched operation SHALL be applied to the shadow buffer on the EXEC cycle edge; max throughput is one operation per 2 cycles.
REQ-022 WRITE with cursor < MAX SHALL store data at index cursor and increment cursor; with cursor == MAX it SHALL leave the shadow unchanged and pulse overflow for 1 cycle.
REQ-023 BACKSPACE with cursor > 0 SHALL decrement cursor and write BLANK_CHAR at the new index; with cursor == 0 it is a no-op.
REQ-024 CLEAR SHALL fill all positions with BLANK_CHAR and set cursor to 0.
REQ-025 SETCUR SHALL set cursor to min(data[3:0], MAX); the shadow is unchanged.
REQ-026 Any WRITE, BACKSPACE or CLEAR SHALL set dirty, even if content is unchanged; SETCUR and no-ops SHALL NOT.
REQ-027 On the cycle after a vblank rising edge with dirty set, the_line SHALL load the shadow and dirty SHALL clear; the_line never changes at any other time.
REQ-028 If a commit and an EXEC edit fall on the same edge, the_line SHALL take the pre-edit shadow and dirty SHALL remain set.
REQ-029 cursor_pos, line_full and pending SHALL be registered or derived from registers only, with no combinational path from inputs.
REQ-030 Requests arriving while vblank is high SHALL be served normally; edits apply at the next vblank rising edge.

Reset
REQ-031 On rst high at a clock edge, the block SHALL set shadow and the_line to all BLANK_CHAR, cursor 0, dirty 0, overflow 0, state IDLE, and last-grant to B, so A wins the first tie.
REQ-032 Reset SHALL override any operation in EXEC; the latched operation is discarded.

Verification
REQ-033 Reset, then A WRITE 'H','I' with vblank low -> the_line stays all 8'h20; on the vblank rise, the_line[79:64]=8'h48,8'h49, cursor_pos=2, pending falls.
REQ-034 A and B both valid continuously -> grants alternate A,B,A,B; each ready is high 1 cycle and the next ready comes 2 cycles later.
REQ-035 Ten WRITEs then an eleventh WRITE -> line_full=1, overflow pulses exactly 1 cycle, and the shadow is unchanged.
REQ-036 BACKSPACE at cursor 0 -> no change, pending=0; BACKSPACE at cursor 3 -> cursor 2, index 2 = 8'h20.
REQ-037 EXEC edit coincident with a vblank rising edge -> the_line takes the old content and pending stays 1; the next vblank commits the edit.
REQ-038 rst asserted during EXEC of CLEAR after writes -> all outputs return to reset values on the next cycle; no stale commit follows.
